// File: rtl/alu_64_if.sv
// alu_64_if: operand/opcode bus into the ALU and registered result/flags back out.
//   A, B, cntrl                                 : driven by master (issue stage)
//   result, negative, zero, overflow, carry_out : driven by slave (alu_64)
interface alu_64_if;
  logic [63:0] A;
  logic [63:0] B;
  logic [2:0]  cntrl;
  logic [63:0] result;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        carry_out;
  modport master (output A, B, cntrl, input result, negative, zero, overflow, carry_out);
  modport slave  (input A, B, cntrl, output result, negative, zero, overflow, carry_out);
endinterface

// File: rtl/alu_64.sv
// alu_64: 64-bit ALU with registered result and N/Z/V/C flags, one cycle latency.
//   clk   : rising-edge clock
//   reset : asynchronous active-high, clears result and flags (zero reads 1)
//   bus   : alu_64_if slave; A, B, cntrl in; result, negative, zero, overflow, carry_out out
//   cntrl : 000 B, 001 A>>B[5:0], 010 A+B, 011 A-B, 100 A&B, 101 A|B, 110 A^B, 111 zero
//   Macro ALU_SHIFT_EN enables the shifter; without it opcode 001 yields zero like 111.
module alu_64 (
  input logic     clk,
  input logic     reset,
  alu_64_if.slave bus
);
  logic        is_sub;
  logic        is_arith;
  logic [63:0] b_eff;
  logic [64:0] sum;
  logic [63:0] shr;
  logic [63:0] res;
  logic        ovf;
  // Subtract folds into the adder as A + ~B + 1, so carry means "no borrow".
  assign is_sub   = bus.cntrl == 3'b011;
  assign is_arith = bus.cntrl[2:1] == 2'b01;
  assign b_eff    = is_sub ? ~bus.B : bus.B;
  assign sum      = {1'b0, bus.A} + {1'b0, b_eff} + {64'd0, is_sub};
  // Same-sign inputs to the adder with a flipped result sign; b_eff covers add and sub alike.
  assign ovf      = (bus.A[63] == b_eff[63]) && (sum[63] != bus.A[63]);
`ifdef ALU_SHIFT_EN
  assign shr = bus.A >> bus.B[5:0];
`else
  assign shr = 64'd0;
`endif
  always_comb begin
    res = 64'd0;
    case (bus.cntrl)
      3'b000:  res = bus.B;
      3'b001:  res = shr;
      3'b010,
      3'b011:  res = sum[63:0];
      3'b100:  res = bus.A & bus.B;
      3'b101:  res = bus.A | bus.B;
      3'b110:  res = bus.A ^ bus.B;
      default: res = 64'd0;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.result    <= 64'd0;
      bus.negative  <= 1'b0;
      bus.zero      <= 1'b1;
      bus.overflow  <= 1'b0;
      bus.carry_out <= 1'b0;
    end else begin
      bus.result    <= res;
      bus.negative  <= res[63];
      bus.zero      <= ~|res;
      bus.overflow  <= is_arith & ovf;
      bus.carry_out <= is_arith & sum[64];
    end
  end
endmodule

// File: tb/tb_alu_64.sv
// tb_alu_64: directed self-checking bench for alu_64.
module tb_alu_64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  alu_64_if bus ();
  alu_64 dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag, input logic [63:0] r, input logic n, input logic z,
                           input logic v, input logic c);
    check({tag, ".result"}, bus.result, r);
    check({tag, ".negative"}, {63'd0, bus.negative}, {63'd0, n});
    check({tag, ".zero"}, {63'd0, bus.zero}, {63'd0, z});
    check({tag, ".overflow"}, {63'd0, bus.overflow}, {63'd0, v});
    check({tag, ".carry"}, {63'd0, bus.carry_out}, {63'd0, c});
  endtask
  task automatic drive(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    bus.cntrl = op;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [63:0] a, b, e;
    bus.A = '1;
    bus.B = '1;
    bus.cntrl = 3'b010;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_reset_add", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    check_all("add_ovf", 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(3'b010, 64'd1, 64'd1);
    check_all("add_small", 64'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(3'b011, 64'h1234, 64'h1234);
    check_all("sub_eq", 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(3'b011, 64'h8000_0000_0000_0000, 64'd1);
    check_all("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(3'b011, 64'd5, 64'd3);
    check_all("sub_5_3", 64'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(3'b011, 64'd3, 64'd5);
    check_all("sub_3_5", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int op = 0; op < 4; op++) begin
      for (int i = 0; i < 25; i++) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        e = op == 0 ? b : op == 1 ? (a & b) : op == 2 ? (a | b) : (a ^ b);
        drive(op == 0 ? 3'b000 : op == 1 ? 3'b100 : op == 2 ? 3'b101 : 3'b110, a, b);
        check_all($sformatf("logic_op%0d_%0d", op, i), e, e[63], e == 64'd0, 1'b0, 1'b0);
      end
    end
    drive(3'b000, 64'd7, 64'd0);
    check_all("pass_zero", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(3'b111, '1, '1);
    check_all("op_zero", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef ALU_SHIFT_EN
    drive(3'b001, 64'hF000_0000_0000_0008, 64'd3);
    check_all("shr3", 64'h1E00_0000_0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(3'b001, 64'hF000_0000_0000_0008, 64'd0);
    check_all("shr0", 64'hF000_0000_0000_0008, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(3'b001, 64'h8000_0000_0000_0000, 64'hFFC0 | 64'd63);
    check_all("shr63", 64'd1, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    drive(3'b001, 64'hF000_0000_0000_0008, 64'd3);
    check_all("shr_off", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    drive(3'b010, '1, 64'd2);
    check_all("b2b_add", 64'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(3'b011, 64'd0, 64'd1);
    check_all("b2b_sub", '1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(3'b100, 64'hFF00, 64'h0FF0);
    check_all("b2b_and", 64'h0F00, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    bus.cntrl = 3'b100;
    bus.A = '1;
    bus.B = '1;
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset_hold", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("after_release", '1, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
